// File: rtl/load_return_buffer.sv
// load_return_buffer
//   Captures load responses from the d-cache. For each response it extracts
//   the addressed byte, halfword or word, sign- or zero-extends it, and
//   queues {tag, data} in a small FIFO. It presents the queued results in
//   order to the CDB arbiter under a valid/grant handshake. When the buffer
//   is nearly full it asks load issue to stall. A branch-mispredict flush
//   discards every queued result.
//
// Optional feature (macro LOAD_RET_BYPASS_EN):
//   When the FIFO is empty, an incoming response is presented on cdb_req_*
//   in the same cycle. If it is granted in that cycle, it is not stored.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   flush            discard all queued results (pointers return to 0)
//   ld_valid         d-cache response valid
//   ld_tag           ROB tag of the response
//   ld_word          raw aligned word from the d-cache
//   ld_size          0 = byte, 1 = half, 2/3 = word
//   ld_signed        1 = sign-extend, 0 = zero-extend
//   ld_byte_off      address bits [1:0] of the load
//   cdb_grant        arbiter accepts the presented result this cycle
//   cdb_req_valid    a result is presented
//   cdb_req_tag      tag of the presented result
//   cdb_req_data     extended data of the presented result
//   ld_stall_req     count >= DEPTH-1
//   count            number of queued entries
//   overflow         sticky: a response was dropped (cleared by reset only)

module load_return_buffer #(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     ld_valid,
  input  logic [TAG_WIDTH-1:0]     ld_tag,
  input  logic [DATA_WIDTH-1:0]    ld_word,
  input  logic [1:0]               ld_size,
  input  logic                     ld_signed,
  input  logic [1:0]               ld_byte_off,
  input  logic                     cdb_grant,
  output logic                     cdb_req_valid,
  output logic [TAG_WIDTH-1:0]     cdb_req_tag,
  output logic [DATA_WIDTH-1:0]    cdb_req_data,
  output logic                     ld_stall_req,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int DEPTH_BITS = $clog2(DEPTH);

  logic [DEPTH_BITS:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0]   rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;

  logic [TAG_WIDTH-1:0]  mem_tag  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  logic                  empty, full, fifo_pop, push, drop;
  logic                  byp_taken;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [7:0]            lane8;
  logic [15:0]           lane16;

  // Lane extraction and extension on the input side (little-endian).
  always_comb begin
    lane8    = ld_word[{ld_byte_off, 3'b000} +: 8];
    lane16   = ld_word[{ld_byte_off[1], 4'b0000} +: 16];
    ext_data = ld_word;
    case (ld_size)
      2'd0:    ext_data = {{(DATA_WIDTH-8){ld_signed & lane8[7]}}, lane8};
      2'd1:    ext_data = {{(DATA_WIDTH-16){ld_signed & lane16[15]}}, lane16};
      default: ext_data = ld_word;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]) &&
                 (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);

  // A grant only pops a stored entry; a grant on a bypassed result
  // consumes the input instead of the FIFO.
  assign fifo_pop = !empty && cdb_grant;

`ifdef LOAD_RET_BYPASS_EN
  logic byp_active;
  assign byp_active = empty && ld_valid && !flush;
  assign byp_taken  = byp_active && cdb_grant;
`else
  assign byp_taken  = 1'b0;
`endif

  assign push = ld_valid && (!full || fifo_pop) && !byp_taken;
  assign drop = ld_valid && full && !fifo_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q || drop;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push)     wr_ptr_d = wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem_tag[wr_ptr_q[DEPTH_BITS-1:0]]  <= ld_tag;
      mem_data[wr_ptr_q[DEPTH_BITS-1:0]] <= ext_data;
    end
  end

  // The head output reads as zero while the buffer is empty, so the
  // reset values hold without resetting the storage.
  always_comb begin
    cdb_req_valid = !empty;
    cdb_req_tag   = '0;
    cdb_req_data  = '0;
    if (!empty) begin
      cdb_req_tag  = mem_tag[rd_ptr_q[DEPTH_BITS-1:0]];
      cdb_req_data = mem_data[rd_ptr_q[DEPTH_BITS-1:0]];
    end
`ifdef LOAD_RET_BYPASS_EN
    if (byp_active) begin
      cdb_req_valid = 1'b1;
      cdb_req_tag   = ld_tag;
      cdb_req_data  = ext_data;
    end
`endif
  end

  assign count        = wr_ptr_q - rd_ptr_q;
  assign ld_stall_req = (count >= (DEPTH_BITS+1)'(DEPTH - 1));
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_load_return_buffer.sv
module tb_load_return_buffer;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
`ifdef LOAD_RET_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, ld_valid, ld_signed, cdb_grant;
  logic [TW-1:0] ld_tag;
  logic [31:0]   ld_word;
  logic [1:0]    ld_size, ld_byte_off;
  logic          cdb_req_valid, ld_stall_req, overflow;
  logic [TW-1:0] cdb_req_tag;
  logic [31:0]   cdb_req_data;
  logic [2:0]    count;

  load_return_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ld_valid(ld_valid),
    .ld_tag(ld_tag), .ld_word(ld_word), .ld_size(ld_size),
    .ld_signed(ld_signed), .ld_byte_off(ld_byte_off), .cdb_grant(cdb_grant),
    .cdb_req_valid(cdb_req_valid), .cdb_req_tag(cdb_req_tag),
    .cdb_req_data(cdb_req_data), .ld_stall_req(ld_stall_req),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } ent_t;

  ent_t q[$];
  logic m_ovf  = 1'b0;
  logic chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_err  = 0;

  // Hand-set literal expectations; -1 means "not checked this cycle".
  longint e_val = -1, e_tag = -1, e_data = -1, e_cnt = -1, e_ovf = -1, e_stall = -1;

  function automatic logic [31:0] ext(logic [31:0] w, logic [1:0] sz, logic sg, logic [1:0] off);
    logic [31:0] v;
    int nb;
    if (sz == 2'd0) begin
      nb = 8;
      v = (w >> (8 * int'(off))) & 32'hFF;
    end else if (sz == 2'd1) begin
      nb = 16;
      v = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
    end else begin
      return w;
    end
    if (sg && v[nb-1]) v = v | (32'hFFFF_FFFF << nb);
    return v;
  endfunction

  always @(posedge clk) begin
    chk_en <= 1'b1;
    if (!rst_n) begin
      q.delete();
      m_ovf <= 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      bit was_full, pop, byp;
      ent_t e;
      was_full = (q.size() == DEPTH);
      pop = (q.size() != 0) && cdb_grant;
      byp = BYP && (q.size() == 0) && ld_valid;
      e.tag  = ld_tag;
      e.data = ext(ld_word, ld_size, ld_signed, ld_byte_off);
      if (!(byp && cdb_grant)) begin
        if (pop) void'(q.pop_front());
        if (ld_valid) begin
          if (!was_full || pop) q.push_back(e);
          else m_ovf <= 1'b1;
        end
      end
    end
  end

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model check every cycle, plus literals.
  always @(negedge clk) begin
    if (chk_en) begin
      logic          xv;
      logic [TW-1:0] xt;
      logic [31:0]   xd;
      xv = (q.size() != 0);
      xt = xv ? q[0].tag : '0;
      xd = xv ? q[0].data : '0;
      if (BYP && q.size() == 0 && ld_valid && !flush && rst_n) begin
        xv = 1'b1;
        xt = ld_tag;
        xd = ext(ld_word, ld_size, ld_signed, ld_byte_off);
      end
      chk("valid", cdb_req_valid, xv);
      chk("tag",   cdb_req_tag,   xt);
      chk("data",  cdb_req_data,  xd);
      chk("count", count,         q.size());
      chk("stall", ld_stall_req,  q.size() >= DEPTH - 1);
      chk("ovf",   overflow,      m_ovf);
      if (e_val   >= 0) chk("lit_valid", cdb_req_valid, e_val);
      if (e_tag   >= 0) chk("lit_tag",   cdb_req_tag,   e_tag);
      if (e_data  >= 0) chk("lit_data",  cdb_req_data,  e_data);
      if (e_cnt   >= 0) chk("lit_count", count,         e_cnt);
      if (e_ovf   >= 0) chk("lit_ovf",   overflow,      e_ovf);
      if (e_stall >= 0) chk("lit_stall", ld_stall_req,  e_stall);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    e_val = -1; e_tag = -1; e_data = -1; e_cnt = -1; e_ovf = -1; e_stall = -1;
  endtask

  task automatic drive(logic v, logic [TW-1:0] t, logic [31:0] w, logic [1:0] sz,
                       logic sg, logic [1:0] off, logic g);
    ld_valid = v; ld_tag = t; ld_word = w; ld_size = sz;
    ld_signed = sg; ld_byte_off = off; cdb_grant = g;
  endtask

  task automatic push(logic [TW-1:0] t, logic g);
    drive(1'b1, t, 32'h0101_0101 * t, 2'd2, 1'b0, 2'd0, g);
    $display("push tag=%0d grant=%0d", t, g);
    tick();
  endtask

  // Load with grant held; checks the literal result at the expected cycle.
  task automatic load_check(logic [TW-1:0] t, logic [31:0] w, logic [1:0] sz,
                            logic sg, logic [1:0] off, longint expd);
    drive(1'b1, t, w, sz, sg, off, 1'b1);
    if (BYP) begin e_val = 1; e_tag = t; e_data = expd; end
    $display("load tag=%0d word=%08h size=%0d signed=%0d off=%0d expect=%08h", t, w, sz, sg, off, expd);
    tick();
    ld_valid = 1'b0;
    if (BYP) begin e_val = 0; e_cnt = 0; end
    else begin e_val = 1; e_tag = t; e_data = expd; e_cnt = 1; end
    tick();
    cdb_grant = 1'b0;
    e_val = 0; e_cnt = 0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0, 2'd0, 1'b0, 2'd0, 1'b0);
    tick();
    e_val = 0; e_tag = 0; e_data = 0; e_cnt = 0; e_ovf = 0; e_stall = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // extraction
    load_check(4'd5, 32'h80FF_7F01, 2'd0, 1'b1, 2'd3, 32'hFFFF_FF80);
    load_check(4'd6, 32'h80FF_7F01, 2'd0, 1'b0, 2'd3, 32'h0000_0080);
    load_check(4'd7, 32'h8001_1234, 2'd1, 1'b1, 2'd2, 32'hFFFF_8001);
    load_check(4'd8, 32'h8001_1234, 2'd2, 1'b1, 2'd0, 32'h8001_1234);
    load_check(4'd9, 32'h8001_1234, 2'd1, 1'b0, 2'd1, 32'h0000_1234);

    // fill, stall, overflow, in-order drain
    push(4'd1, 1'b0); e_cnt = 1; e_stall = 0;
    push(4'd2, 1'b0); e_cnt = 2; e_stall = 0;
    push(4'd3, 1'b0); e_cnt = 3; e_stall = 1;
    push(4'd4, 1'b0); e_cnt = 4; e_stall = 1; e_tag = 1; e_ovf = 0;
    push(4'd9, 1'b0);
    ld_valid = 1'b0; cdb_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      e_tag = i; e_data = 32'h0101_0101 * i; e_ovf = 1;
      if (i == 1) e_cnt = 4;
      tick();
    end
    cdb_grant = 1'b0; e_cnt = 0; e_val = 0; e_ovf = 1;
    tick();

    // full with simultaneous push and pop
    push(4'd11, 1'b0); push(4'd12, 1'b0); push(4'd13, 1'b0); push(4'd14, 1'b0);
    e_cnt = 4; e_tag = 11;
    push(4'd15, 1'b1);
    ld_valid = 1'b0; cdb_grant = 1'b1;
    e_cnt = 4; e_tag = 12;
    tick();
    e_tag = 13; tick();
    e_tag = 14; tick();
    e_tag = 15; e_data = 32'h0F0F_0F0F; e_cnt = 1; tick();
    cdb_grant = 1'b0; e_cnt = 0; tick();

    // flush with a coincident response
    push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd3, 1'b0);
    e_cnt = 3;
    flush = 1'b1;
    drive(1'b1, 4'd4, 32'h1234_5678, 2'd2, 1'b0, 2'd0, 1'b0);
    $display("flush with ld_valid tag=4");
    tick();
    flush = 1'b0; ld_valid = 1'b0;
    e_cnt = 0; e_val = 0; e_ovf = 1; e_data = 0;
    tick();

    // reset mid-operation
    push(4'd5, 1'b0); push(4'd6, 1'b0);
    ld_valid = 1'b0; rst_n = 1'b0; e_cnt = 2;
    $display("reset mid-operation");
    tick();
    rst_n = 1'b1;
    e_val = 0; e_tag = 0; e_data = 0; e_cnt = 0; e_ovf = 0; e_stall = 0;
    tick();

    // mixed traffic checked against the model
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 3) != 0), TW'($urandom), 32'($urandom),
            2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom_range(0, 2) == 0));
      flush = ($urandom_range(0, 19) == 0);
      $display("mixed v=%0d tag=%0d grant=%0d flush=%0d", ld_valid, ld_tag, cdb_grant, flush);
      tick();
    end
    flush = 1'b0; ld_valid = 1'b0; cdb_grant = 1'b1;
    repeat (6) tick();
    e_cnt = 0; e_val = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
